// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/function constants, the NOP encoding and
// the fetch-unit FSM state type.
package mips_pkg;

    localparam logic [5:0]  OP_RTYPE   = 6'd0;
    localparam logic [5:0]  OP_J       = 6'd2;
    localparam logic [5:0]  OP_JAL     = 6'd3;
    localparam logic [5:0]  OP_BEQ     = 6'd4;
    localparam logic [5:0]  OP_BNE     = 6'd5;
    localparam logic [5:0]  FN_JR      = 6'd8;
    localparam logic [5:0]  FN_SYSCALL = 6'd12;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction ROM bus between the fetch unit and the asynchronous-read ROM.
//   imem_addr  : word address driven by the fetch unit
//   imem_rdata : combinational ROM data returned to the fetch unit
// master = fetch unit, slave = ROM.
interface instr_fetch_unit_if #(
    parameter int unsigned IMEM_ADDR_W = 10
);
    logic [IMEM_ADDR_W-1:0] imem_addr;
    logic [31:0]            imem_rdata;

    modport master (output imem_addr, input  imem_rdata);
    modport slave  (input  imem_addr, output imem_rdata);
endinterface

// File: rtl/next_pc_calc.sv
// Combinational next-PC arithmetic for the IF stage.
//   pc, id_pc4   : current fetch PC and the IF/ID PC+4
//   instr_low    : id_instr[25:0] (imm16 / target26 fields)
//   rs_val       : forwarded rs value (JR target)
//   sel_jr/jump  : redirect kind; neither set selects the branch target
//   pc_plus4     : sequential PC
//   target       : selected redirect target
module next_pc_calc (
    input  logic [31:0] pc,
    input  logic [31:0] id_pc4,
    input  logic [25:0] instr_low,
    input  logic [31:0] rs_val,
    input  logic        sel_jr,
    input  logic        sel_jump,
    output logic [31:0] pc_plus4,
    output logic [31:0] target
);
    logic [15:0] imm16;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] jr_target;

    always_comb begin
        imm16     = instr_low[15:0];
        pc_plus4  = pc + 32'd4;
        br_target = id_pc4 + {{14{imm16[15]}}, imm16, 2'b00};
        j_target  = {id_pc4[31:28], instr_low, 2'b00};
        jr_target = rs_val & ~32'h3;
        if (sel_jr)
            target = jr_target;
        else if (sel_jump)
            target = j_target;
        else
            target = br_target;
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage plus IF/ID pipeline register of the 5-stage MIPS pipeline.
//   clk, rst_n        : clock, asynchronous active-low reset
//   stall             : load-use stall, freezes PC and IF/ID
//   beq..syscall_halt : ID-stage decoder outputs
//   rs_eq_rt, rs_val  : ID-stage comparator and forwarded rs
//   go                : resume from HALT
//   imem              : instruction ROM bus (master side)
//   id_instr/id_pc4/id_valid, op, func : IF/ID register and decoded fields
//   pc, halted, taken_cnt              : fetch PC, HALT flag, redirect count
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET    = 32'h0000_0000,
    parameter int unsigned IMEM_ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  beq,
    input  logic                  bne,
    input  logic                  jmp,
    input  logic                  jal,
    input  logic                  jr,
    input  logic                  syscall_halt,
    input  logic                  rs_eq_rt,
    input  logic [31:0]           rs_val,
    input  logic                  go,
    instr_fetch_unit_if.master    imem,
    output logic [31:0]           id_instr,
    output logic [31:0]           id_pc4,
    output logic                  id_valid,
    output logic [5:0]            op,
    output logic [5:0]            func,
    output logic [31:0]           pc,
    output logic                  halted,
    output logic [15:0]           taken_cnt
);
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  id_instr_q, id_instr_d;
    logic [31:0]  id_pc4_q, id_pc4_d;
    logic         id_valid_q, id_valid_d;
    logic [15:0]  taken_cnt_q, taken_cnt_d;

    logic         qual;
    logic         halt_req;
    logic         taken;
    logic [31:0]  pc_plus4;
    logic [31:0]  target;

    next_pc_calc u_next_pc_calc (
        .pc        (pc_q),
        .id_pc4    (id_pc4_q),
        .instr_low (id_instr_q[25:0]),
        .rs_val    (rs_val),
        .sel_jr    (jr),
        .sel_jump  (jmp || jal),
        .pc_plus4  (pc_plus4),
        .target    (target)
    );

    // A stalled ID instruction has unresolved operands, so it may not act.
    always_comb begin
        qual     = id_valid_q && !stall;
        halt_req = qual && syscall_halt;
        taken    = qual && ((beq && rs_eq_rt) || (bne && !rs_eq_rt) || jmp || jal || jr);
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        id_instr_d  = id_instr_q;
        id_pc4_d    = id_pc4_q;
        id_valid_d  = id_valid_q;
        taken_cnt_d = taken_cnt_q;
        case (state_q)
            S_RUN: begin
                if (halt_req) begin
                    id_instr_d = NOP_INSTR;
                    id_valid_d = 1'b0;
                    state_d    = S_HALT;
                end else if (taken) begin
                    pc_d       = target;
                    id_instr_d = NOP_INSTR;
                    id_valid_d = 1'b0;
                    if (taken_cnt_q != '1)
                        taken_cnt_d = taken_cnt_q + 16'd1;
                end else if (!stall) begin
                    pc_d       = pc_plus4;
                    id_instr_d = imem.imem_rdata;
                    id_pc4_d   = pc_plus4;
                    id_valid_d = 1'b1;
                end
            end
            S_HALT: begin
                if (go)
                    state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            pc_q        <= PC_RESET;
            id_instr_q  <= NOP_INSTR;
            id_pc4_q    <= '0;
            id_valid_q  <= 1'b0;
            taken_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            id_instr_q  <= id_instr_d;
            id_pc4_q    <= id_pc4_d;
            id_valid_q  <= id_valid_d;
            taken_cnt_q <= taken_cnt_d;
        end
    end

    assign imem.imem_addr = pc_q[IMEM_ADDR_W+1:2];
    assign id_instr       = id_instr_q;
    assign id_pc4         = id_pc4_q;
    assign id_valid       = id_valid_q;
    assign op             = id_instr_q[31:26];
    assign func           = id_instr_q[5:0];
    assign pc             = pc_q;
    assign halted         = (state_q == S_HALT);
    assign taken_cnt      = taken_cnt_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, beq, bne, jmp, jal, jr, syscall_halt, rs_eq_rt, go;
    logic [31:0] rs_val;
    logic [31:0] id_instr, id_pc4, pc;
    logic        id_valid, halted;
    logic [5:0]  op, func;
    logic [15:0] taken_cnt;

    logic [31:0] rom [0:1023];

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        valid;
        logic        halted;
        logic [15:0] cnt;
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;
    exp_t sb[$];

    instr_fetch_unit_if #(.IMEM_ADDR_W(10)) bus ();
    assign bus.imem_rdata = rom[bus.imem_addr];

    instr_fetch_unit #(.PC_RESET(32'h0000_0000), .IMEM_ADDR_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .beq(beq), .bne(bne),
        .jmp(jmp), .jal(jal), .jr(jr), .syscall_halt(syscall_halt),
        .rs_eq_rt(rs_eq_rt), .rs_val(rs_val), .go(go), .imem(bus.master),
        .id_instr(id_instr), .id_pc4(id_pc4), .id_valid(id_valid),
        .op(op), .func(func), .pc(pc), .halted(halted), .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Push the expected post-edge state, advance one edge, pop and compare.
    task automatic step(string tag, logic [31:0] e_pc, logic e_v, logic e_h,
                        logic [15:0] e_cnt, logic [31:0] e_instr, logic [31:0] e_pc4);
        exp_t e;
        e = '{tag, e_pc, e_v, e_h, e_cnt, e_instr, e_pc4};
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".pc"},     pc,                e.pc);
        chk({e.tag, ".valid"},  {31'd0, id_valid}, {31'd0, e.valid});
        chk({e.tag, ".halted"}, {31'd0, halted},   {31'd0, e.halted});
        chk({e.tag, ".cnt"},    {16'd0, taken_cnt}, {16'd0, e.cnt});
        chk({e.tag, ".instr"},  id_instr,          e.instr);
        if (e.valid)
            chk({e.tag, ".pc4"}, id_pc4, e.pc4);
    endtask

    task automatic clear_inputs();
        stall = 0; beq = 0; bne = 0; jmp = 0; jal = 0; jr = 0;
        syscall_halt = 0; rs_eq_rt = 0; rs_val = '0; go = 0;
    endtask

    task automatic do_reset(string tag);
        clear_inputs();
        rst_n = 0;
        #3;
        chk({tag, ".pc"},    pc,       32'h0);
        chk({tag, ".instr"}, id_instr, NOP_INSTR);
        chk({tag, ".pc4"},   id_pc4,   32'h0);
        chk({tag, ".vhc"},   {14'd0, id_valid, halted, taken_cnt}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic run_to_beq();
        for (int i = 0; i < 5; i++)
            step($sformatf("seq%0d", i), 32'(4 * (i + 1)), 1'b1, 1'b0, 16'd0,
                 rom[i], 32'(4 * (i + 1)));
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 32'h2008_0000 | 32'(i);
        rom[0]    = 32'h2008_0005;
        rom[4]    = {OP_BEQ, 5'd1, 5'd2, 16'h0003};
        rom[8]    = {OP_BEQ, 5'd1, 5'd2, 16'hFFFF};
        rom[15]   = {OP_RTYPE, 20'd0, FN_SYSCALL};
        rom[16'h40] = {OP_J, 26'd15};

        // Reset and first fetch
        do_reset("rst0");
        step("first", 32'h4, 1, 0, 16'd0, 32'h2008_0005, 32'h4);
        chk("first.op",   {26'd0, op},   32'd8);
        chk("first.func", {26'd0, func}, 32'd5);
        for (int i = 1; i < 5; i++)
            step($sformatf("seqa%0d", i), 32'(4 * (i + 1)), 1, 0, 16'd0, rom[i], 32'(4 * (i + 1)));

        // BEQ not taken
        beq = 1; rs_eq_rt = 0;
        step("beq_nt", 32'h18, 1, 0, 16'd0, rom[5], 32'h18);
        beq = 0;

        // BEQ taken, forward
        do_reset("rst1");
        run_to_beq();
        beq = 1; rs_eq_rt = 1;
        step("beq_t", 32'h20, 0, 0, 16'd1, NOP_INSTR, 32'h0);
        beq = 0;
        step("after_beq", 32'h24, 1, 0, 16'd1, rom[8], 32'h24);

        // BEQ taken, backward
        beq = 1; rs_eq_rt = 1;
        step("beq_back", 32'h20, 0, 0, 16'd2, NOP_INSTR, 32'h0);
        beq = 0; rs_eq_rt = 0;
        step("refetch", 32'h24, 1, 0, 16'd2, rom[8], 32'h24);

        // JR under a 2-cycle stall
        jr = 1; rs_val = 32'h0000_0103; stall = 1;
        step("jr_stall0", 32'h24, 1, 0, 16'd2, rom[8], 32'h24);
        step("jr_stall1", 32'h24, 1, 0, 16'd2, rom[8], 32'h24);
        stall = 0;
        step("jr_go", 32'h100, 0, 0, 16'd3, NOP_INSTR, 32'h0);
        jr = 0;
        step("after_jr", 32'h104, 1, 0, 16'd3, rom[16'h40], 32'h104);

        // J to the SYSCALL
        jmp = 1;
        step("j", 32'h3C, 0, 0, 16'd4, NOP_INSTR, 32'h0);
        jmp = 0;
        step("fetch_sys", 32'h40, 1, 0, 16'd4, rom[15], 32'h40);

        // Halt, redirects ignored, resume
        syscall_halt = 1;
        step("halt", 32'h40, 0, 1, 16'd4, NOP_INSTR, 32'h0);
        syscall_halt = 0; beq = 1; rs_eq_rt = 1; jmp = 1;
        for (int i = 0; i < 5; i++)
            step($sformatf("halted%0d", i), 32'h40, 0, 1, 16'd4, NOP_INSTR, 32'h0);
        beq = 0; rs_eq_rt = 0; jmp = 0; go = 1;
        step("go", 32'h40, 0, 0, 16'd4, NOP_INSTR, 32'h0);
        go = 0;
        step("resume", 32'h44, 1, 0, 16'd4, rom[16'h10], 32'h44);
        go = 1;
        step("go_in_run", 32'h48, 1, 0, 16'd4, rom[16'h11], 32'h48);
        go = 0;

        // Counter saturation
        do_reset("rst2");
        step("sat_f0", 32'h4, 1, 0, 16'd0, rom[0], 32'h4);
        force dut.taken_cnt_q = 16'hFFFD;
        #1;
        release dut.taken_cnt_q;
        jr = 1; rs_val = 32'h0;
        step("sat_j0", 32'h0, 0, 0, 16'hFFFE, NOP_INSTR, 32'h0);
        step("sat_f1", 32'h4, 1, 0, 16'hFFFE, rom[0], 32'h4);
        step("sat_j1", 32'h0, 0, 0, 16'hFFFF, NOP_INSTR, 32'h0);
        step("sat_f2", 32'h4, 1, 0, 16'hFFFF, rom[0], 32'h4);
        step("sat_j2", 32'h0, 0, 0, 16'hFFFF, NOP_INSTR, 32'h0);
        jr = 0;
        step("sat_f3", 32'h4, 1, 0, 16'hFFFF, rom[0], 32'h4);

        // Asynchronous reset while halted
        syscall_halt = 1;
        step("halt2", 32'h4, 0, 1, 16'hFFFF, NOP_INSTR, 32'h0);
        syscall_halt = 0;
        #3;
        rst_n = 0;
        #1;
        chk("arst.halted", {31'd0, halted},   32'd0);
        chk("arst.pc",     pc,                32'h0);
        chk("arst.valid",  {31'd0, id_valid}, 32'd0);
        chk("arst.cnt",    {16'd0, taken_cnt}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
